spectral_peak_picker: RTL
=========================

Name: spectral_peak_picker

Overview:
Consumes the per-bin magnitude stream produced by the FFT stage (FFT_IMPLEMENTATION magnitude/magnitude_ready) and builds the constellation points for fingerprinting. For each FFT frame it scans the non-mirrored half of the spectrum, splits it into fixed log-spaced bands, and finds the strongest bin per band. Each band maximum at or above a threshold becomes a peak record (frame, band, bin, magnitude). Peak records are buffered in a small FIFO and drained downstream via valid/ready.

Parameters:
N_BINS, 1024, FFT length; bins arrive 0..N_BINS-1 per frame, only 0..N_BINS/2-1 are scanned
MAG_W, 16, magnitude width (unsigned)
FIFO_DEPTH, 8, peak record buffer depth (power of 2)
FRAME_W, 16, frame counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_clear  in  1  synchronous resync: restart bin count at 0, discard partial band maxima
magnitude_ready  in  1  one magnitude bin valid this cycle
magnitude  in  MAG_W  unsigned bin magnitude
threshold  in  MAG_W  minimum magnitude for a peak to be emitted (quasi-static)
peak_valid  out  1  FIFO head record valid
peak_ready  in  1  downstream accepts head record
peak_frame  out  FRAME_W  frame index of record
peak_band  out  3  band index 0..5
peak_bin  out  $clog2(N_BINS/2)  bin index within frame
peak_mag  out  MAG_W  band maximum magnitude
frame_done  out  1  one-cycle pulse after bin N_BINS-1 consumed
overflow  out  1  sticky: a peak record was dropped on full FIFO

Behaviour:
- Reset (async, active-high): bin_cnt=0, frame_cnt=0, band=0, band_max=0, band_bin=0, FIFO empty; outputs peak_valid=0, frame_done=0, overflow=0, peak_* = 0.
- Bin counter: increments on each magnitude_ready; wraps N_BINS-1 -> 0; on wrap frame_cnt++ (wraps modulo 2^FRAME_W) and frame_done pulses the following cycle.
- States: SCAN (bin_cnt < N_BINS/2) and SKIP (upper mirrored half, inputs counted but ignored). SCAN->SKIP when bin N_BINS/2-1 consumed; SKIP->SCAN on wrap.
- Band edges (inclusive upper bins, N_BINS=1024): 9, 19, 39, 79, 159, 511. Edges scale by N_BINS/1024 for other sizes.
- In SCAN, per accepted bin: if magnitude > band_max (strict) or first bin of band, capture magnitude and bin. Ties keep lowest bin index.
- At band's last bin (using the updated max including that bin): if max >= threshold, push {frame_cnt, band, band_bin, max} into FIFO; reset band_max, band++ (band 5 -> 0).
- Push latency: record visible at peak_valid 1 cycle after the magnitude_ready of the band's last bin when FIFO was empty.
- Handshake: record pops when peak_valid && peak_ready; peak_* hold stable while peak_valid && !peak_ready. Push and pop in the same cycle on a full FIFO both succeed (no drop).
- FIFO full on push (no simultaneous pop): record dropped, overflow set; overflow is cleared only by reset.
- frame_clear: takes priority over magnitude_ready in the same cycle; bin_cnt=0, band=0, band_max=0, state SCAN; frame_cnt and FIFO contents unchanged.
- magnitude_ready gaps of any length are permitted; state holds.
- Max six records per frame; threshold=0 emits exactly six per frame.

Decomposition:
- Package spectral_pkg: MAG_W default, band count (6), band edge constant array, peak record struct typedef {frame, band, bin, mag}.
- One sub-module: peak_fifo (synchronous FIFO of peak records, full/empty, simultaneous push/pop). Scan FSM and band tracking stay in the top.

Test Plan:
- Three tones: magnitudes 1000 at bins 8, 19, 30 (and mirrored 1016, 1005, 994), 5 elsewhere, threshold=64 -> exactly 3 records: (f0, b0, bin8, 1000), (f0, b1, bin19, 1000), (f0, b2, bin30, 1000); frame_done pulses once; mirrored bins produce nothing.
- Tie: bins 12 and 15 both 500 -> record band1 bin12 mag500.
- threshold=0, peak_ready=0 for two frames -> 8 records stored, remaining 4 dropped, overflow=1, peak_valid stays 1 with frame0 band0 at head.
- Backpressure: toggle peak_ready every other cycle during a frame -> all records delivered in order, no loss, fields stable while stalled.
- frame_clear asserted at bin 300, then full frame with peak at bin 3 -> first emitted record after clear is band0 bin3; no record for the interrupted band 5.
- Async reset asserted mid-SCAN with 2 records queued -> peak_valid=0, overflow=0 immediately; next frame reports frame index 0.

Source files
------------

// File: rtl/spectral_peak_picker_pkg.sv
// Shared widths, band layout and the peak record type for the spectral peak picker.
package spectral_pkg;
   localparam int MAG_W      = 16;
   localparam int FRAME_W    = 16;
   localparam int N_BINS_DEF = 1024;
   localparam int BIN_W      = $clog2(N_BINS_DEF / 2);
   localparam int N_BANDS    = 6;
   localparam int BAND_W     = 3;

   // Inclusive last bin of each log-spaced band for a 1024-point frame
   localparam int BAND_LAST_1024 [N_BANDS] = '{9, 19, 39, 79, 159, 511};

   typedef enum logic {SCAN, SKIP} scan_state_e;

   typedef struct packed {
      logic [FRAME_W-1:0] frame;
      logic [BAND_W-1:0]  band;
      logic [BIN_W-1:0]   bin;
      logic [MAG_W-1:0]   mag;
   } peak_rec_t;

   function automatic int band_last(input int band, input int n_bins);
      return (BAND_LAST_1024[band] + 1) * n_bins / 1024 - 1;
   endfunction
endpackage

// File: rtl/spectral_peak_picker_if.sv
// Magnitude stream in, peak records out (valid/ready).
interface spectral_peak_picker_if;
   import spectral_pkg::*;

   logic               mag_ready;
   logic [MAG_W-1:0]   mag;
   logic               peak_valid;
   logic               peak_ready;
   logic [FRAME_W-1:0] peak_frame;
   logic [BAND_W-1:0]  peak_band;
   logic [BIN_W-1:0]   peak_bin;
   logic [MAG_W-1:0]   peak_mag;

   modport master (output mag_ready, mag, peak_ready,
                   input  peak_valid, peak_frame, peak_band, peak_bin, peak_mag);
   modport slave  (input  mag_ready, mag, peak_ready,
                   output peak_valid, peak_frame, peak_band, peak_bin, peak_mag);
endinterface

// File: rtl/spectral_peak_picker_fifo.sv
// Synchronous FIFO of peak records; a push on full succeeds only alongside a pop.
module peak_fifo import spectral_pkg::*; #(
   parameter int DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  peak_rec_t rec_i,
   input  logic      pop_i,
   output peak_rec_t rec_o,
   output logic      empty_o,
   output logic      full_o
);
   localparam int AW = $clog2(DEPTH);

   peak_rec_t     mem_q [DEPTH];
   logic [AW:0]   wr_q, rd_q;
   logic          do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rec_o   = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= rec_i;
   end
endmodule

// File: rtl/spectral_peak_picker.sv
// Per-frame band maximum search over the lower half-spectrum, emitting peak records.
module spectral_peak_picker import spectral_pkg::*; #(
   parameter int N_BINS     = N_BINS_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_clear_i,
   input  logic [MAG_W-1:0]       threshold_i,
   spectral_peak_picker_if.slave  sp_if,
   output logic                   frame_done_o,
   output logic                   overflow_o
);
   localparam int CNT_W = $clog2(N_BINS);

   scan_state_e        state_q, state_d;
   logic [CNT_W-1:0]   bin_q, bin_d, max_bin_q, max_bin_d, last_bin, cur_bin;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [BAND_W-1:0]  band_q, band_d;
   logic [MAG_W-1:0]   max_q, max_d, cur_max;
   logic               first_q, first_d, frame_done_q, frame_done_d, overflow_q;
   logic               push, pop, full, empty;
   peak_rec_t          rec, head;

   always_comb begin
      last_bin = '0;
      for (int b = 0; b < N_BANDS; b++)
         if (band_q == BAND_W'(b)) last_bin = CNT_W'(band_last(b, N_BINS));
   end

   always_comb begin
      state_d      = state_q;
      bin_d        = bin_q;
      frame_d      = frame_q;
      band_d       = band_q;
      max_d        = max_q;
      max_bin_d    = max_bin_q;
      first_d      = first_q;
      frame_done_d = 1'b0;
      push         = 1'b0;
      cur_max      = max_q;
      cur_bin      = max_bin_q;
      if (frame_clear_i) begin
         state_d   = SCAN;
         bin_d     = '0;
         band_d    = '0;
         max_d     = '0;
         max_bin_d = '0;
         first_d   = 1'b1;
      end else if (sp_if.mag_ready) begin
         bin_d = bin_q + 1'b1;
         if (bin_q == CNT_W'(N_BINS - 1)) begin
            bin_d        = '0;
            frame_d      = frame_q + 1'b1;
            frame_done_d = 1'b1;
            state_d      = SCAN;
         end
         if (state_q == SCAN) begin
            // Strict compare keeps the lowest bin on ties
            if (first_q || sp_if.mag > max_q) begin
               cur_max = sp_if.mag;
               cur_bin = bin_q;
            end
            if (bin_q == last_bin) begin
               push      = (cur_max >= threshold_i);
               band_d    = (band_q == BAND_W'(N_BANDS - 1)) ? '0 : band_q + 1'b1;
               max_d     = '0;
               max_bin_d = '0;
               first_d   = 1'b1;
               if (bin_q == CNT_W'(N_BINS / 2 - 1)) state_d = SKIP;
            end else begin
               max_d     = cur_max;
               max_bin_d = cur_bin;
               first_d   = 1'b0;
            end
         end
      end
   end

   always_comb begin
      rec.frame = frame_q;
      rec.band  = band_q;
      rec.bin   = BIN_W'(cur_bin);
      rec.mag   = cur_max;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SCAN;
         bin_q        <= '0;
         frame_q      <= '0;
         band_q       <= '0;
         max_q        <= '0;
         max_bin_q    <= '0;
         first_q      <= 1'b1;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bin_q        <= bin_d;
         frame_q      <= frame_d;
         band_q       <= band_d;
         max_q        <= max_d;
         max_bin_q    <= max_bin_d;
         first_q      <= first_d;
         frame_done_q <= frame_done_d;
         if (push && full && !pop) overflow_q <= 1'b1;
      end
   end

   assign pop = !empty && sp_if.peak_ready;

   peak_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .rec_i   (rec),
      .pop_i   (pop),
      .rec_o   (head),
      .empty_o (empty),
      .full_o  (full)
   );

   assign sp_if.peak_valid = !empty;
   assign sp_if.peak_frame = empty ? '0 : head.frame;
   assign sp_if.peak_band  = empty ? '0 : head.band;
   assign sp_if.peak_bin   = empty ? '0 : head.bin;
   assign sp_if.peak_mag   = empty ? '0 : head.mag;
   assign frame_done_o     = frame_done_q;
   assign overflow_o       = overflow_q;
endmodule
